mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the fetch/LSU memory port arbiter.
// Holds the width defaults, the FSM state encoding and the owner codes.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_LSU   = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input request picker, purely combinational (zero latency, no backpressure).
// Ties go to the port that did not win last, or always to the LSU in fixed mode.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = OWNER_FETCH;
        case (req)
            2'b01:   grant_idx = OWNER_FETCH;
            2'b10:   grant_idx = OWNER_LSU;
            2'b11:   grant_idx = fixed_prio ? OWNER_LSU : ~last_grant;
            default: grant_idx = OWNER_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and LSU (port 1), one transaction at a time.
// Accept at T, mem_req from T+1 until ack, rsp pulse the cycle after ack; readys stay low while busy.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_we,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_sel,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_sel;
    logic              r_last_grant;
    logic              r_p0_rsp;
    logic              r_p1_rsp;
    logic [DATA_W-1:0] r_rdata;

    logic              w_grant_valid;
    logic              w_grant_idx;
    logic              w_accept;
    logic              w_p0_ready;
    logic              w_p1_ready;

    rr_pick2 u_pick (
        .req         ({p1_valid, p0_valid}),
        .last_grant  (r_last_grant),
        .fixed_prio  (FIXED_PRIO != 0),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_p0_ready  = 1'b0;
        w_p1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset blocks the handshake so nothing is accepted and then discarded.
                if (w_grant_valid && !reset) begin
                    w_accept    = 1'b1;
                    w_p0_ready  = (w_grant_idx == OWNER_FETCH);
                    w_p1_ready  = (w_grant_idx == OWNER_LSU);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_sel        <= OWNER_FETCH;
            r_last_grant <= OWNER_LSU;
            r_p0_rsp     <= 1'b0;
            r_p1_rsp     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_p0_rsp <= 1'b0;
            r_p1_rsp <= 1'b0;
            if (w_accept) begin
                r_sel        <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                if (w_grant_idx == OWNER_LSU) begin
                    r_addr  <= p1_addr;
                    r_wdata <= p1_wdata;
                    r_we    <= p1_we;
                end else begin
                    r_addr  <= p0_addr;
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                end
            end
            if (r_state == BUSY && mem_ack) begin
                r_p0_rsp <= (r_sel == OWNER_FETCH);
                r_p1_rsp <= (r_sel == OWNER_LSU);
                r_rdata  <= r_we ? '0 : mem_rdata;
            end
        end
    end

    assign p0_ready     = w_p0_ready;
    assign p1_ready     = w_p1_ready;
    assign p0_rsp_valid = r_p0_rsp;
    assign p1_rsp_valid = r_p1_rsp;
    assign rsp_rdata    = r_rdata;
    assign mem_req      = (r_state == BUSY);
    assign busy         = (r_state == BUSY);
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_we       = r_we;
    assign mem_sel      = r_sel;

endmodule
